// File: rtl/fifo_rd.sv
// fifo_rd - read-side controller for the 8-bit test FIFO.
//
// Waits for the FIFO to report full and then drains it in one burst with a
// registered rd_en. Every returned word is presented on dout with a one-cycle
// dout_vld strobe. The module then returns to idle.
//
// Optional checker: define FIFO_RD_CHK_EN to compare each captured word against
// an incrementing byte sequence. On a mismatch the expected value resynchronises
// to the received word. Without the macro, err and err_cnt are tied to 0.
//
// Parameters:
//   RD_LATENCY   FIFO read latency, rd_en sampled high -> rd_data valid (1..3)
//   ERR_CNT_W    width of the saturating mismatch counter
//
// Ports:
//   clk_100m      in   system clock
//   rst_n         in   asynchronous active-low reset
//   full          in   FIFO full flag (asynchronous, synchronised here)
//   empty         in   FIFO empty flag
//   almost_empty  in   FIFO almost-empty flag (at most one word left)
//   rd_data[7:0]  in   FIFO read data
//   rd_en         out  FIFO read enable (registered)
//   dout[7:0]     out  captured read word
//   dout_vld      out  one-cycle strobe per captured word
//   busy          out  high while a burst is in READ or DRAIN
//   burst_done    out  one-cycle pulse at the end of a burst
//   err           out  sticky data-mismatch flag
//   err_cnt       out  saturating mismatch count
module fifo_rd #(
  parameter int RD_LATENCY = 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 full,
  input  logic                 empty,
  input  logic                 almost_empty,
  input  logic [7:0]           rd_data,
  output logic                 rd_en,
  output logic [7:0]           dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 burst_done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  // The DRAIN counter runs from RD_LATENCY-1 down to 0, so DRAIN lasts
  // RD_LATENCY cycles. That is long enough for the last read's data to be
  // captured. Two bits cover the legal latency range.
  localparam logic [1:0] DRAIN_LOAD = 2'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  full_d0_q, full_d1_q;
  logic                  rd_en_q, rd_en_d;
  logic                  burst_done_q, burst_done_d;
  logic [1:0]            drain_cnt_q, drain_cnt_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  strobe;
  logic [7:0]            dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;

  // Shift register of issued reads. Its last stage marks the cycle in which
  // rd_data holds the word for a read issued RD_LATENCY edges earlier.
  if (RD_LATENCY == 1) begin : g_pipe_1
    assign pipe_d = rd_en_q;
  end else begin : g_pipe_n
    assign pipe_d = {pipe_q[RD_LATENCY-2:0], rd_en_q};
  end
  assign strobe = pipe_q[RD_LATENCY-1];

  // State register and all other control/data flops.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      full_d0_q    <= 1'b0;
      full_d1_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      burst_done_q <= 1'b0;
      drain_cnt_q  <= 2'd0;
      pipe_q       <= '0;
      dout_q       <= 8'h00;
      dout_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_d0_q    <= full;
      full_d1_q    <= full_d0_q;
      rd_en_q      <= rd_en_d;
      burst_done_q <= burst_done_d;
      drain_cnt_q  <= drain_cnt_d;
      pipe_q       <= pipe_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (full_d1_q && !empty)     state_d = S_READ;
      S_READ:  if (almost_empty || empty)   state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q == 2'd0)     state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Next values of the registered FSM outputs.
  always_comb begin
    rd_en_d      = 1'b0;
    burst_done_d = 1'b0;
    drain_cnt_d  = drain_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        rd_en_d = full_d1_q && !empty;
      end
      S_READ: begin
        // Stop one word early. The read issued on this edge takes the last
        // word, so rd_en is never high while empty is sampled.
        rd_en_d     = !(almost_empty || empty);
        drain_cnt_d = DRAIN_LOAD;
      end
      S_DRAIN: begin
        if (drain_cnt_q == 2'd0) burst_done_d = 1'b1;
        else                     drain_cnt_d  = drain_cnt_q - 2'd1;
      end
      default: begin
        rd_en_d = 1'b0;
      end
    endcase
  end

  // Capture path: dout holds its value between words.
  always_comb begin
    dout_vld_d = strobe;
    dout_d     = strobe ? rd_data : dout_q;
  end

  assign rd_en      = rd_en_q;
  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign busy       = (state_q != S_IDLE);
  assign burst_done = burst_done_q;

`ifdef FIFO_RD_CHK_EN
  logic [7:0]           exp_q, exp_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 8'h00;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Check the word that is being captured on this edge. After a mismatch,
  // continue from the received value so one bad word counts only once.
  always_comb begin
    exp_d     = exp_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (strobe) begin
      if (rd_data == exp_q) begin
        exp_d = exp_q + 8'd1;
      end else begin
        err_d = 1'b1;
        exp_d = rd_data + 8'd1;
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
